// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, flag bundle and opcode range shared by the ALU core and pipeline stage
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOR = 4'd5,
        OP_NOT = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8
    } alu_op_e;

    localparam int OP_LAST = 8;

    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
        logic ovf;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath
//   A, B   : operands
//   Op     : opcode
//   Result : computed result (0 for undefined opcodes)
//   Flags  : zero/carry/neg/ovf/illegal derived from this op and Result
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  alu_op_e          Op,
    output logic [WIDTH-1:0] Result,
    output alu_flags_t       Flags
);

    logic             is_add;
    logic             is_sub;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             cy;

    // SUB reuses the adder as A + ~B + 1, so its carry out means "no borrow"
    always_comb begin
        is_add = (Op == OP_ADD);
        is_sub = (Op == OP_SUB);
        b_in   = is_sub ? ~B : B;
        sum    = {1'b0, A} + {1'b0, b_in} + (WIDTH + 1)'(is_sub);
        res    = '0;
        cy     = 1'b0;
        case (Op)
            OP_ADD, OP_SUB: begin
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_NOR: res = ~(A | B);
            OP_NOT: res = ~A;
            OP_SHL: begin
                res = {A[WIDTH-2:0], 1'b0};
                cy  = A[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, A[WIDTH-1:1]};
                cy  = A[0];
            end
            default: res = '0;
        endcase
        Result        = res;
        Flags.zero    = (res == '0);
        Flags.carry   = cy;
        Flags.neg     = res[WIDTH-1];
        Flags.ovf     = is_add ? (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]) :
                        is_sub ? (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]) : 1'b0;
        Flags.illegal = int'(Op) > OP_LAST;
    end

endmodule

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: two-stage valid/ready pipeline around alu_core
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (A, B, Op)
//   out_valid/out_ready : result handshake (Result, Zero, Carry, Neg, Ovf, Illegal)
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Neg,
    output logic             Ovf,
    output logic             Illegal
);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    alu_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;
    logic             s2_ready;
    logic             in_xfer;
    logic             s1_move;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .A      (a_q),
        .B      (b_q),
        .Op     (alu_op_e'(op_q)),
        .Result (core_result),
        .Flags  (core_flags)
    );

    // Ready looks through both stages so a draining output frees s2 and s1 in the same cycle
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_ready;
        in_xfer    = in_valid && in_ready;
        s1_move    = s1_valid_q && s2_ready;
        a_d        = in_xfer ? A : a_q;
        b_d        = in_xfer ? B : b_q;
        op_d       = in_xfer ? Op : op_q;
        s1_valid_d = in_xfer ? 1'b1 : (s2_ready ? 1'b0 : s1_valid_q);
        result_d   = s1_move ? core_result : result_q;
        flags_d    = s1_move ? core_flags : flags_q;
        s2_valid_d = s1_move ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign Result    = result_q;
    assign Zero      = flags_q.zero;
    assign Carry     = flags_q.carry;
    assign Neg       = flags_q.neg;
    assign Ovf       = flags_q.ovf;
    assign Illegal   = flags_q.illegal;

endmodule
